// File: rtl/rdma_req_split_pkg.sv
// Shared types for the RDMA request splitter: field widths, per-request
// metadata carried onto every chunk, and the FSM state encoding.
package rdma_req_split_pkg;
  localparam int VADDR_BITS     = 48;
  localparam int LEN_BITS       = 28;
  localparam int DEST_BITS      = 4;
  localparam int PID_BITS       = 6;
  localparam int N_REGIONS_BITS = 1;

  typedef struct packed {
    logic                      ctl;
    logic                      stream;
    logic                      sync;
    logic                      host;
    logic [DEST_BITS-1:0]      dest;
    logic [PID_BITS-1:0]       pid;
    logic [N_REGIONS_BITS-1:0] vfid;
  } req_split_meta_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SPLIT = 1'b1
  } split_state_e;
endpackage

// File: rtl/rdma_req_split_if.sv
// Valid/ready memory request channel used on both sides of the splitter.
interface rdma_req_split_if;
  import rdma_req_split_pkg::*;

  logic                      valid;
  logic                      ready;
  logic [VADDR_BITS-1:0]     vaddr;
  logic [LEN_BITS-1:0]       len;
  logic                      ctl;
  logic                      stream;
  logic                      sync;
  logic                      host;
  logic [DEST_BITS-1:0]      dest;
  logic [PID_BITS-1:0]       pid;
  logic [N_REGIONS_BITS-1:0] vfid;

  modport master (output valid, vaddr, len, ctl, stream, sync, host, dest, pid, vfid,
                  input  ready);
  modport slave  (input  valid, vaddr, len, ctl, stream, sync, host, dest, pid, vfid,
                  output ready);
endinterface

// File: rtl/rdma_req_split.sv
// Splits one memory request at a time into chunks that never cross a
// 2^BOUND_BITS-byte boundary; the output channel is fully registered.
module rdma_req_split
  import rdma_req_split_pkg::*;
#(
  parameter int BOUND_BITS = 12
) (
  input  logic              nclk,
  input  logic              nresetn,
  rdma_req_split_if.slave   s_req,
  rdma_req_split_if.master  m_req,
  output logic              busy
);

  function automatic logic [LEN_BITS-1:0] chunk_len(input logic [VADDR_BITS-1:0] addr,
                                                    input logic [LEN_BITS-1:0]   rem);
    logic [LEN_BITS-1:0] room;
    room = (LEN_BITS'(1) << BOUND_BITS) - LEN_BITS'(addr[BOUND_BITS-1:0]);
    return (rem < room) ? rem : room;
  endfunction

  split_state_e          state_q, state_d;
  logic [LEN_BITS-1:0]   rem_q, rem_d;
  logic [VADDR_BITS-1:0] addr_q, addr_d;
  req_split_meta_t       meta_q, meta_d;
  logic                  vld_q, vld_d;
  logic [VADDR_BITS-1:0] oaddr_q, oaddr_d;
  logic [LEN_BITS-1:0]   olen_q, olen_d;
  logic                  octl_q, octl_d;
  logic                  busy_q, busy_d;

  logic                  load_ok;
  logic                  s_ready;
  logic [LEN_BITS-1:0]   clen, nrem;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    addr_d  = addr_q;
    meta_d  = meta_q;
    vld_d   = vld_q;
    oaddr_d = oaddr_q;
    olen_d  = olen_q;
    octl_d  = octl_q;
    busy_d  = busy_q;
    s_ready = 1'b0;
    clen    = '0;
    nrem    = '0;
    load_ok = !vld_q || m_req.ready;

    // A consumed chunk drops valid unless a new one is loaded below.
    if (load_ok) vld_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        s_ready = load_ok;
        if (s_req.valid && load_ok) begin
          clen           = chunk_len(s_req.vaddr, s_req.len);
          nrem           = s_req.len - clen;
          vld_d          = 1'b1;
          oaddr_d        = s_req.vaddr;
          olen_d         = clen;
          octl_d         = (nrem == '0) ? s_req.ctl : 1'b0;
          meta_d.ctl     = s_req.ctl;
          meta_d.stream  = s_req.stream;
          meta_d.sync    = s_req.sync;
          meta_d.host    = s_req.host;
          meta_d.dest    = s_req.dest;
          meta_d.pid     = s_req.pid;
          meta_d.vfid    = s_req.vfid;
          addr_d         = s_req.vaddr + VADDR_BITS'(clen);
          rem_d          = nrem;
          if (nrem != '0) begin
            state_d = ST_SPLIT;
            busy_d  = 1'b1;
          end
        end
      end
      ST_SPLIT: begin
        if (load_ok) begin
          clen    = chunk_len(addr_q, rem_q);
          nrem    = rem_q - clen;
          vld_d   = 1'b1;
          oaddr_d = addr_q;
          olen_d  = clen;
          octl_d  = (nrem == '0) ? meta_q.ctl : 1'b0;
          addr_d  = addr_q + VADDR_BITS'(clen);
          rem_d   = nrem;
          if (nrem == '0) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge nclk) begin
    if (!nresetn) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      addr_q  <= '0;
      meta_q  <= '0;
      vld_q   <= 1'b0;
      oaddr_q <= '0;
      olen_q  <= '0;
      octl_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      addr_q  <= addr_d;
      meta_q  <= meta_d;
      vld_q   <= vld_d;
      oaddr_q <= oaddr_d;
      olen_q  <= olen_d;
      octl_q  <= octl_d;
      busy_q  <= busy_d;
    end
  end

  assign s_req.ready  = s_ready;
  assign m_req.valid  = vld_q;
  assign m_req.vaddr  = oaddr_q;
  assign m_req.len    = olen_q;
  assign m_req.ctl    = octl_q;
  assign m_req.stream = meta_q.stream;
  assign m_req.sync   = meta_q.sync;
  assign m_req.host   = meta_q.host;
  assign m_req.dest   = meta_q.dest;
  assign m_req.pid    = meta_q.pid;
  assign m_req.vfid   = meta_q.vfid;
  assign busy         = busy_q;

endmodule
